// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// default memory word-address width and the alignment helper.
// Optional feature macro used by importers: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam int LSU_ADDR_W = 12;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 is also handled as a word

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LDATA = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4
    } lsu_state_t;

    // A halfword must sit on an even byte and a word on a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        if (sz == SZ_HALF)
            mis = a[0];
        else if (sz != SZ_BYTE)
            mis = (a != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Latency: purely combinational. Backpressure: none, a pure function of its inputs.
// Ports: size_i/lane_i select the lane, sign_ext_i picks sign vs zero extension,
//        rd_word_i is the word read from memory, st_data_i the right-aligned store
//        data; ld_data_o is the extended load value, merge_word_o the word to write.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sign_ext_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] merge_word_o
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        sh_b   = {lane_i, 3'b000};
        sh_h   = {lane_i[1], 4'b0000};
        byte_v = rd_word_i[sh_b +: 8];
        half_v = rd_word_i[sh_h +: 16];

        ld_data_o    = rd_word_i;
        merge_word_o = st_data_i;
        case (size_i)
            SZ_BYTE: begin
                ld_data_o    = {{24{sign_ext_i & byte_v[7]}}, byte_v};
                merge_word_o = (rd_word_i & ~(32'h0000_00FF << sh_b))
                             | ({24'd0, st_data_i[7:0]} << sh_b);
            end
            SZ_HALF: begin
                ld_data_o    = {{16{sign_ext_i & half_v[15]}}, half_v};
                merge_word_o = (rd_word_i & ~(32'h0000_FFFF << sh_h))
                             | ({16'd0, st_data_i[15:0]} << sh_h);
            end
            default: begin
                ld_data_o    = rd_word_i;
                merge_word_o = st_data_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller in front of a word-wide synchronous data memory.
// Latency: load 3 cycles, word store 2, sub-word store (read-modify-write) 3, misaligned err 1.
// Backpressure: busy is high while an access is in flight; req is ignored while busy.
// Ports: req/we/size/sign_ext/addr/wdata from the pipeline; busy/done/rdata/err back to it;
//        mem_da/mem_wdata/mem_read/mem_write to the memory, mem_doa from it.
// Option: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with err;
//         otherwise they are force-aligned and err stays 0.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_da,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_doa
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] da_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              trap;
    logic              sub_word;
    logic [1:0]        lane_acc;
    logic [31:0]       ld_data;
    logic [31:0]       merge_word;

    // Address bits above the memory window are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign accept   = (state_q == ST_IDLE) && req;
    assign sub_word = (size == SZ_BYTE) || (size == SZ_HALF);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = accept && is_misaligned(size, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Lane selection drops the low offset bits for halfwords and words, which
    // is exactly the force-alignment used when misaligned accesses are not trapped.
    always_comb begin
        case (size)
            SZ_BYTE: lane_acc = addr[1:0];
            SZ_HALF: lane_acc = {addr[1], 1'b0};
            default: lane_acc = 2'b00;
        endcase
    end

    lsu_lane_mux u_lane_mux (
        .size_i       (size_q),
        .lane_i       (lane_q),
        .sign_ext_i   (sign_q),
        .rd_word_i    (mem_doa),
        .st_data_i    (wdata_q),
        .ld_data_o    (ld_data),
        .merge_word_o (merge_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !trap)
                    state_d = (!we || sub_word) ? ST_RD : ST_WR;
            end
            ST_RD:    state_d = we_q ? ST_MERGE : ST_LDATA;
            ST_LDATA: state_d = ST_IDLE;
            ST_MERGE: state_d = ST_IDLE;
            ST_WR:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs. The write strobe is masked by reset so that an
    // access aborted in MERGE or WR never reaches memory on the reset cycle.
    always_comb begin
        mem_wdata = 32'd0;
        case (state_q)
            ST_MERGE: mem_wdata = merge_word;
            ST_WR:    mem_wdata = wdata_q;
            default:  mem_wdata = 32'd0;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_read  = (state_q == ST_RD);
    assign mem_write = ((state_q == ST_MERGE) || (state_q == ST_WR)) && !rst;
    assign mem_da    = da_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            da_q    <= '0;
            lane_q  <= 2'b00;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_LDATA) || (state_q == ST_MERGE) || (state_q == ST_WR);
            err_q   <= trap;
            // All request fields are captured at accept, so the pipeline side
            // may change freely while the access is in flight.
            if (accept && !trap) begin
                da_q    <= addr[ADDR_W+1:2];
                lane_q  <= lane_acc;
                size_q  <= size;
                sign_q  <= sign_ext;
                we_q    <= we;
                wdata_q <= wdata;
            end
            if (state_q == ST_LDATA)
                rdata_q <= ld_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [11:0] mem_da;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_doa;

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_da    (mem_da),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_doa   (mem_doa)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: reads on posedge, writes on negedge.
    logic [31:0] mem     [4096];
    logic [31:0] ref_mem [4096];

    always @(posedge clk) if (mem_read) mem_doa <= mem[mem_da];
    always @(negedge clk) if (mem_write) mem[mem_da] <= mem_wdata;

    typedef struct {
        bit          is_err;
        bit          is_load;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: architectural effect of one access on ref_mem.
    task automatic model(input bit st, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output bit is_err, output logic [31:0] res, output int lat);
        int          idx;
        int          k;
        bit          mis;
        logic [31:0] w;
        logic [31:0] b;
        idx    = int'(a[13:2]);
        k      = int'(a[1:0]);
        mis    = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
        is_err = 1'b0;
        res    = 32'd0;
        lat    = 3;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            is_err = 1'b1;
            lat    = 1;
            return;
        end
`else
        if (mis) k = (sz == 2'd1) ? (k / 2) * 2 : 0;
`endif
        w = ref_mem[idx];
        if (!st) begin
            if (sz == 2'd0) begin
                b   = (w >> (8 * k)) & 32'hFF;
                res = (sx && b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            end else if (sz == 2'd1) begin
                b   = (w >> (8 * k)) & 32'hFFFF;
                res = (sx && b >= 32'h8000) ? b + 32'hFFFF_0000 : b;
            end else begin
                res = w;
            end
        end else begin
            if (sz == 2'd0)
                ref_mem[idx] = (w & ~(32'hFF << (8 * k))) | ((d & 32'hFF) << (8 * k));
            else if (sz == 2'd1)
                ref_mem[idx] = (w & ~(32'hFFFF << (8 * k))) | ((d & 32'hFFFF) << (8 * k));
            else begin
                ref_mem[idx] = d;
                lat = 2;
            end
        end
    endtask

    // Issue one access at a negedge once the unit is idle; junk on req/addr
    // while busy must be ignored by the DUT.
    task automatic issue(input bit st, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] d);
        int          guard;
        bit          is_err;
        logic [31:0] res;
        int          lat;
        exp_t        e;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            req   = 1'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            we    = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("busy_timeout", {31'd0, busy}, 32'd0);
        we = st; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        model(st, sz, sx, a, d, is_err, res, lat);
        e.is_err  = is_err;
        e.is_load = !st;
        e.rdata   = res;
        e.cyc     = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        if (is_err) begin
            check("trap_busy", {31'd0, busy}, 32'd0);
            check("trap_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        end else begin
            check("busy_cycle1", {31'd0, busy}, 32'd1);
            check("mem_da", {20'd0, mem_da}, {20'd0, a[13:2]});
            if (st && sz >= 2'd2)
                check("wr_strobes", {30'd0, mem_read, mem_write}, 32'd1);
            else
                check("rd_strobes", {30'd0, mem_read, mem_write}, 32'd2);
        end
        addr  = $urandom;
        wdata = $urandom;
        size  = 2'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("drain_timeout", sb.size(), 32'd0);
    endtask

    // Monitor: compares every done/err pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_response: done=%b err=%b with nothing outstanding", done, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
                check("latency", cyc, e.cyc);
                if (e.is_load && !e.is_err) check("rdata", rdata, e.rdata);
            end
        end
    end

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_da", {20'd0, mem_da}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Directed sequence.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA);
        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001);
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        drain();
        check("word4_after_sh", mem[4], 32'h8001AAEF);

        // Reset during MERGE of sb 0x55 @ 0x10.
        @(negedge clk);
        we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h55; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_merge_no_write", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        check("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("abort_outputs", rdata | mem_wdata | {20'd0, mem_da}, 32'd0);
        check("abort_word4", mem[4], ref_mem[4]);

        // Upper address bits ignored.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0);

        // Randomized traffic within a 16-word window, junk upper address bits.
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            issue(1'($urandom), 2'($urandom), 1'($urandom),
                  (r & 32'hFFFF_C000) | 32'($urandom_range(0, 63)), $urandom);
        end
        drain();

        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
